// File: rtl/dm_access_ctrl_if.sv
// Request/response bundle between the control unit (master) and the
// wait-state data-memory controller (slave).
interface dm_access_ctrl_if #(
   parameter int unsigned DATA_W = 32
);
   logic              MemRd;
   logic              MemWr;
   logic [31:0]       addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output MemRd, MemWr, addr, wdata,
      input  rdata, busy, done, err
   );

   modport slave (
      input  MemRd, MemWr, addr, wdata,
      output rdata, busy, done, err
   );
endinterface

// File: rtl/dm_access_ctrl.sv
// Wait-state data-memory controller: accepts one read/write, stalls for LAT
// cycles, then commits the access and pulses done (or err for bad requests).
module dm_access_ctrl #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LAT    = 2
) (
   input logic              clk,
   input logic              rst,
   dm_access_ctrl_if.slave  bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                op_wr_q, op_wr_d;
   logic [ADDR_W-1:0]   addr_lat_q, addr_lat_d;
   logic [DATA_W-1:0]   wdata_lat_q, wdata_lat_d;
   logic [DATA_W-1:0]   rdata_q;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                addr_oob;

   assign addr_oob = |bus.addr[31:ADDR_W];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_wr_d     = op_wr_q;
      addr_lat_d  = addr_lat_q;
      wdata_lat_d = wdata_lat_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.MemRd && bus.MemWr) begin
               err_d = 1'b1;
            end else if (bus.MemRd || bus.MemWr) begin
               if (addr_oob) begin
                  err_d = 1'b1;
               end else begin
                  op_wr_d     = bus.MemWr;
                  addr_lat_d  = bus.addr[ADDR_W-1:0];
                  wdata_lat_d = bus.wdata;
                  cnt_d       = 4'(LAT);
                  state_d     = (LAT == 0) ? StDone : StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = StDone;
            end
         end
         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Reset wins over an in-flight write: the commit below is skipped entirely.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         op_wr_q     <= 1'b0;
         addr_lat_q  <= '0;
         wdata_lat_q <= '0;
         rdata_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_wr_q     <= op_wr_d;
         addr_lat_q  <= addr_lat_d;
         wdata_lat_q <= wdata_lat_d;
         done_q      <= done_d;
         err_q       <= err_d;
         if (state_q == StDone) begin
            if (op_wr_q) begin
               mem_q[addr_lat_q] <= wdata_lat_q;
            end else begin
               rdata_q <= mem_q[addr_lat_q];
            end
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.busy  = (state_q != StIdle);
   assign bus.done  = done_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: a LAT=2 instance for the main sequence
// and a LAT=0 instance for zero-wait and back-to-back behaviour.
module tb_dm_access_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   dm_access_ctrl_if #(.DATA_W(32)) bus2 ();
   dm_access_ctrl_if #(.DATA_W(32)) bus0 ();

   dm_access_ctrl #(.ADDR_W(5), .DATA_W(32), .LAT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   dm_access_ctrl #(.ADDR_W(5), .DATA_W(32), .LAT(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the edge; inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request on the LAT=2 instance; wdata is scrambled after acceptance.
   task automatic access2(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
      bus2.MemRd = rd;
      bus2.MemWr = wr;
      bus2.addr  = a;
      bus2.wdata = d;
      tick();
      bus2.MemRd = 1'b0;
      bus2.MemWr = 1'b0;
      bus2.wdata = 32'hFFFF_FFFF;
      check({tag, " busy@N"}, bus2.busy, 1'b1);
      for (int i = 1; i <= 2; i++) begin
         tick();
         check({tag, " busy@wait"}, bus2.busy, 1'b1);
         check({tag, " done@wait"}, bus2.done, 1'b0);
      end
      tick();
      check({tag, " done@N+3"}, bus2.done, 1'b1);
      check({tag, " busy@N+3"}, bus2.busy, 1'b0);
      check({tag, " err@N+3"}, bus2.err, 1'b0);
      tick();
      check({tag, " done drop"}, bus2.done, 1'b0);
   endtask

   task automatic bad_req2(input logic rd, input logic wr, input logic [31:0] a, input string tag);
      bus2.MemRd = rd;
      bus2.MemWr = wr;
      bus2.addr  = a;
      bus2.wdata = 32'h0;
      tick();
      bus2.MemRd = 1'b0;
      bus2.MemWr = 1'b0;
      check({tag, " err"}, bus2.err, 1'b1);
      check({tag, " busy"}, bus2.busy, 1'b0);
      check({tag, " done"}, bus2.done, 1'b0);
      tick();
      check({tag, " err drop"}, bus2.err, 1'b0);
      check({tag, " busy after"}, bus2.busy, 1'b0);
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      rst        = 1'b1;
      bus2.MemRd = 1'b0;
      bus2.MemWr = 1'b0;
      bus2.addr  = '0;
      bus2.wdata = '0;
      bus0.MemRd = 1'b0;
      bus0.MemWr = 1'b0;
      bus0.addr  = '0;
      bus0.wdata = '0;

      tick();
      tick();
      rst = 1'b0;
      check("rst rdata", bus2.rdata, 32'h0);
      check("rst busy", bus2.busy, 1'b0);
      check("rst done", bus2.done, 1'b0);
      check("rst err", bus2.err, 1'b0);
      tick();

      access2(1'b1, 1'b0, 32'd16, 32'h0, "rd16");
      check("rd16 rdata", bus2.rdata, 32'h0);

      access2(1'b0, 1'b1, 32'd17, 32'h0000_00A5, "wr17");
      access2(1'b1, 1'b0, 32'd17, 32'h0, "rd17");
      check("rd17 rdata", bus2.rdata, 32'h0000_00A5);

      access2(1'b0, 1'b1, 32'd20, 32'h0000_1234, "wr20");
      check("wr20 rdata kept", bus2.rdata, 32'h0000_00A5);
      access2(1'b1, 1'b0, 32'd20, 32'h0, "rd20");
      check("rd20 latched wdata", bus2.rdata, 32'h0000_1234);

      bad_req2(1'b1, 1'b1, 32'd17, "both");
      access2(1'b1, 1'b0, 32'd17, 32'h0, "rd17b");
      check("rd17 after both-err", bus2.rdata, 32'h0000_00A5);

      bad_req2(1'b1, 1'b0, 32'd32, "oob");
      check("oob rdata kept", bus2.rdata, 32'h0000_00A5);

      // Reset lands in the WAIT cycle of a write to address 18.
      bus2.MemWr = 1'b1;
      bus2.addr  = 32'd18;
      bus2.wdata = 32'h55;
      tick();
      bus2.MemWr = 1'b0;
      check("rstmid busy@N", bus2.busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid busy", bus2.busy, 1'b0);
      check("rstmid rdata", bus2.rdata, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rstmid no done", bus2.done, 1'b0);
      end
      access2(1'b1, 1'b0, 32'd18, 32'h0, "rd18");
      check("rd18 dropped write", bus2.rdata, 32'h0);
      access2(1'b1, 1'b0, 32'd17, 32'h0, "rd17c");
      check("rd17 cleared", bus2.rdata, 32'h0);

      // Zero-latency instance.
      bus0.MemWr = 1'b1;
      bus0.addr  = 32'd19;
      bus0.wdata = 32'h7;
      tick();
      bus0.MemWr = 1'b0;
      check("l0 wr busy@N", bus0.busy, 1'b1);
      check("l0 wr done@N", bus0.done, 1'b0);
      tick();
      check("l0 wr done@N+1", bus0.done, 1'b1);
      check("l0 wr busy@N+1", bus0.busy, 1'b0);
      tick();
      bus0.MemRd = 1'b1;
      bus0.addr  = 32'd19;
      tick();
      check("l0 rd busy@N", bus0.busy, 1'b1);
      check("l0 rd done@N", bus0.done, 1'b0);
      tick();
      check("l0 rd done@N+1", bus0.done, 1'b1);
      check("l0 rd rdata", bus0.rdata, 32'h7);
      tick();
      bus0.MemRd = 1'b0;
      check("l0 held busy@N+2", bus0.busy, 1'b1);
      check("l0 held done@N+2", bus0.done, 1'b0);
      tick();
      check("l0 held done@N+3", bus0.done, 1'b1);
      check("l0 held rdata", bus0.rdata, 32'h7);
      tick();
      check("l0 idle done", bus0.done, 1'b0);
      check("l0 idle busy", bus0.busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
